// File: rtl/rr_elastic_arbiter.sv
// rr_elastic_arbiter: round-robin arbiter feeding one elastic valid/ready
// output register shared by num_req_p requesters. One cycle of latency,
// one beat per cycle, fair rotation between requesters.
// Optional packet lock (keeps the grant until last_i) is enabled by defining
// RR_ELASTIC_ARBITER_LOCK_EN.
module rr_elastic_arbiter #(
  parameter int width_p   = 8,
  parameter int num_req_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic [num_req_p*width_p-1:0]   data_i,
  input  logic [num_req_p-1:0]           valid_i,
  input  logic [num_req_p-1:0]           last_i,
  output logic [num_req_p-1:0]           ready_o,
  output logic                           valid_o,
  output logic [width_p-1:0]             data_o,
  output logic                           last_o,
  output logic [$clog2(num_req_p)-1:0]   src_o,
  input  logic                           ready_i
);
  localparam int iw = $clog2(num_req_p);
  // One extra bit so ptr+offset can be folded back below num_req_p.
  localparam logic [iw:0]   n_ext    = (iw+1)'(num_req_p);
  localparam logic [iw-1:0] last_idx = iw'(num_req_p - 1);

  logic               valid_l, last_l;
  logic [width_p-1:0] data_l;
  logic [iw-1:0]      src_l, ptr;
  logic               en, found, xfer;
  logic [iw-1:0]      win, ptr_nxt;
  logic [iw:0]        cand;
`ifdef RR_ELASTIC_ARBITER_LOCK_EN
  logic               lock_l;
  logic [iw-1:0]      lock_id_l;
`endif

  assign en   = ~valid_l | ready_i;
  // Gating with reset_ni keeps ready_o low for the whole reset window.
  assign xfer = en & found & reset_ni;
  // Wrap modulo num_req_p so ptr never reaches an unused index.
  assign ptr_nxt = (win == last_idx) ? '0 : win + 1'b1;

  // Winner: first valid requester searching from ptr; a held lock overrides.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cand = {1'b0, ptr} + (iw+1)'(i);
      if (cand >= n_ext) cand = cand - n_ext;
      if (!found && valid_i[cand[iw-1:0]]) begin
        found = 1'b1;
        win   = cand[iw-1:0];
      end
    end
`ifdef RR_ELASTIC_ARBITER_LOCK_EN
    if (lock_l) begin
      found = valid_i[lock_id_l];
      win   = lock_id_l;
    end
`endif
  end

  // One-hot ready to the winner only when the stage can take a beat.
  always_comb begin
    ready_o = '0;
    if (xfer) ready_o[win] = 1'b1;
  end

  // Output register, priority pointer and packet lock.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_l   <= 1'b0;
      data_l    <= '0;
      last_l    <= 1'b0;
      src_l     <= '0;
      ptr       <= '0;
`ifdef RR_ELASTIC_ARBITER_LOCK_EN
      lock_l    <= 1'b0;
      lock_id_l <= '0;
`endif
    end else if (xfer) begin
      valid_l <= 1'b1;
      data_l  <= data_i[win*width_p +: width_p];
      last_l  <= last_i[win];
      src_l   <= win;
`ifdef RR_ELASTIC_ARBITER_LOCK_EN
      if (last_i[win]) begin
        lock_l <= 1'b0;
        ptr    <= ptr_nxt;
      end else begin
        // Mid-packet: pin the grant, leave ptr for after the packet.
        lock_l    <= 1'b1;
        lock_id_l <= win;
      end
`else
      ptr <= ptr_nxt;
`endif
    end else if (en) begin
      valid_l <= 1'b0;
    end
  end

  assign valid_o = valid_l;
  assign data_o  = data_l;
  assign last_o  = last_l;
  assign src_o   = src_l;
endmodule

// File: tb/tb_rr_elastic_arbiter.sv
// Bench for rr_elastic_arbiter: N=4 instance checked every cycle against a
// queue-free behavioural model plus literal expectations; N=3 instance for
// the wrap-around case.
module tb_rr_elastic_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_ni = 1'b0;
  logic [N*W-1:0] data_i;
  logic [N-1:0] valid_i, last_i, ready_o;
  logic         ready_i, valid_o, last_o;
  logic [W-1:0] data_o;
  logic [1:0]   src_o;

  logic [3*W-1:0] d3;
  logic [2:0]   v3, l3, r3o;
  logic         v3o, l3o;
  logic [W-1:0] d3o;
  logic [1:0]   s3o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_elastic_arbiter #(.width_p(W), .num_req_p(N)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
    .last_o(last_o), .src_o(src_o), .ready_i(ready_i));

  rr_elastic_arbiter #(.width_p(W), .num_req_p(3)) dut3 (
    .clk_i(clk), .reset_ni(reset_ni), .data_i(d3), .valid_i(v3),
    .last_i(l3), .ready_o(r3o), .valid_o(v3o), .data_o(d3o),
    .last_o(l3o), .src_o(s3o), .ready_i(1'b1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  int        m_ptr, m_src, m_lock_id, m_win;
  bit        m_valid, m_last, m_lock;
  logic [W-1:0] m_data;
  logic [N-1:0] m_rdy;

  function automatic int model_winner(input logic [N-1:0] v, input int p,
                                      input bit lk, input int lid);
`ifdef RR_ELASTIC_ARBITER_LOCK_EN
    if (lk) return v[lid] ? lid : -1;
`endif
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  always_comb begin
    m_win = model_winner(valid_i, m_ptr, m_lock, m_lock_id);
    m_rdy = '0;
    if (reset_ni && (!m_valid || ready_i) && m_win >= 0) m_rdy = N'(1) << m_win;
  end

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      m_valid <= 0; m_data <= '0; m_last <= 0; m_src <= 0;
      m_ptr <= 0; m_lock <= 0; m_lock_id <= 0;
    end else if ((!m_valid || ready_i) && m_win >= 0) begin
      m_valid <= 1;
      m_data  <= data_i[m_win*W +: W];
      m_last  <= last_i[m_win];
      m_src   <= m_win;
`ifdef RR_ELASTIC_ARBITER_LOCK_EN
      if (!last_i[m_win]) begin
        m_lock <= 1; m_lock_id <= m_win;
      end else begin
        m_lock <= 0; m_ptr <= (m_win + 1) % N;
      end
`else
      m_ptr <= (m_win + 1) % N;
`endif
    end else if (!m_valid || ready_i) begin
      m_valid <= 0;
    end
  end

  // ---- every-cycle compare against the model ----
  initial forever begin
    @(negedge clk);
    check("m_ready", ready_o, m_rdy);
    check("m_valid", valid_o, m_valid);
    check("m_data",  data_o,  m_data);
    check("m_last",  last_o,  m_last);
    check("m_src",   src_o,   m_src);
  end

  // ---- directed stimulus with literal expectations ----
  initial begin
    ready_i = 1'b1;
    valid_i = 4'b1111;
    last_i  = 4'b1111;
    for (int k = 0; k < N; k++) data_i[k*W +: W] = W'(8'h10 + k);
    v3 = 3'b000; l3 = 3'b111;
    for (int k = 0; k < 3; k++) d3[k*W +: W] = W'(8'h20 + k);

    // reset held with all requesters valid
    repeat (2) @(negedge clk);
    check("rst_ready", ready_o, 4'b0000);
    check("rst_valid", valid_o, 1'b0);
    check("rst_data",  data_o,  8'h00);
    check("rst_src",   src_o,   2'd0);
    @(posedge clk); #1 reset_ni = 1'b1;
    @(negedge clk);
    check("first_ready", ready_o, 4'b0001);

    // rotation 0x10,0x11,0x12,0x13,0x10
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rot_data", data_o, 8'h10 + (i % 4));
      check("rot_src",  src_o,  i % 4);
      check("rot_valid", valid_o, 1'b1);
    end

    // back-pressure for 3 cycles while holding 0x11
    @(posedge clk); #1 ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", ready_o, 4'b0000);
      check("bp_data",  data_o,  8'h11);
    end
    @(posedge clk); #1 ready_i = 1'b1;
    @(negedge clk);
    check("bp_release_ready", ready_o, 4'b0100);
    check("bp_release_data",  data_o,  8'h11);
    @(negedge clk);
    check("bp_next_data", data_o, 8'h12);

    // packet from requester 1 with requester 2 also valid
    @(posedge clk); #1 valid_i = 4'b0110; last_i = 4'b0000;
    @(negedge clk);
    check("pkt_first_ready", ready_o, 4'b0010);
    @(negedge clk);
    check("pkt_b1_src", src_o, 2'd1);
`ifdef RR_ELASTIC_ARBITER_LOCK_EN
    check("pkt_lock_ready", ready_o, 4'b0010);
`else
    check("pkt_rr_ready", ready_o, 4'b0100);
`endif
    @(posedge clk); #1 valid_i = 4'b0100;
    @(negedge clk);
`ifdef RR_ELASTIC_ARBITER_LOCK_EN
    check("pkt_b2_src", src_o, 2'd1);
    check("pkt_gap_ready", ready_o, 4'b0000);
`else
    check("pkt_b2_src", src_o, 2'd2);
    check("pkt_gap_ready", ready_o, 4'b0100);
`endif
    @(posedge clk); #1 valid_i = 4'b0110; last_i = 4'b0010;
    @(negedge clk);
`ifdef RR_ELASTIC_ARBITER_LOCK_EN
    check("pkt_gap_valid", valid_o, 1'b0);
`else
    check("pkt_gap_src", src_o, 2'd2);
`endif
    @(posedge clk); #1 last_i = 4'b0000;
    @(negedge clk);
    check("pkt_b3_src",  src_o,  2'd1);
    check("pkt_b3_last", last_o, 1'b1);
    @(negedge clk);
    check("pkt_after_src", src_o, 2'd2);
`ifdef RR_ELASTIC_ARBITER_LOCK_EN
    check("pkt2_lock_ready", ready_o, 4'b0100);
`else
    check("pkt2_rr_ready", ready_o, 4'b0010);
`endif

    // asynchronous reset between edges, mid-packet
    @(posedge clk); #3 reset_ni = 1'b0;
    #1;
    check("arst_valid", valid_o, 1'b0);
    check("arst_ready", ready_o, 4'b0000);
    check("arst_data",  data_o,  8'h00);
    check("arst_src",   src_o,   2'd0);
    #2 reset_ni = 1'b1; valid_i = 4'b0111; last_i = 4'b1111;
    #1;
    check("arst_rel_ready", ready_o, 4'b0001);
    @(negedge clk);
    check("arst_rel_src",  src_o,  2'd0);
    check("arst_rel_data", data_o, 8'h10);

    // N=3 wrap: move ptr to 2, then only requesters 2 and 0 valid
    @(posedge clk); #1 v3 = 3'b010;
    @(negedge clk);
    check("w3_ready1", r3o, 3'b010);
    @(posedge clk); #1 v3 = 3'b101;
    @(negedge clk);
    check("w3_src1",   s3o, 2'd1);
    check("w3_ready2", r3o, 3'b100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("w3_src",  s3o, (i % 2 == 0) ? 2'd2 : 2'd0);
      check("w3_data", d3o, (i % 2 == 0) ? 8'h22 : 8'h20);
      check("w3_valid", v3o, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_elastic_arbiter.md
# rr_elastic_arbiter

Round-robin arbiter that shares one elastic valid/ready output stage between `num_req_p` requesters. Each cycle the output register can accept, the block grants the highest-priority valid requester and captures its beat into a single pipeline register. The block sits in front of a shared downstream consumer such as a bus port or functional unit. It provides one cycle of latency, full throughput and fair rotation between requesters.

## Interface
Parameters:
- `width_p`, 8, payload width per requester
- `num_req_p`, 4, number of requesters; legal range ≥ 2, not required to be a power of two

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge
- `reset_ni`  in  1  reset; asynchronous, active-low
- `data_i`  in  `num_req_p*width_p`  requester payloads; requester k occupies bits `[k*width_p +: width_p]`
- `valid_i`  in  `num_req_p`  per-requester valid
- `last_i`  in  `num_req_p`  per-requester end-of-packet flag
- `ready_o`  out  `num_req_p`  per-requester ready; at most one bit high
- `valid_o`  out  1  output register holds a beat
- `data_o`  out  `width_p`  registered payload
- `last_o`  out  1  registered `last_i` of the captured beat
- `src_o`  out  `$clog2(num_req_p)`  index of the requester that supplied the registered beat
- `ready_i`  in  1  downstream ready

## Operation
- **Output register.** Holds `valid_l`, `data_l`, `last_l` and `src_l`.
  - Stage enable is `en = ~valid_l | ready_i`, with the same semantics as the team's elastic stage.
- **Priority pointer.** `ptr` has width `$clog2(num_req_p)` and holds values 0..`num_req_p-1`.
  - Search order is `ptr`, `ptr+1`, …, with wrap modulo `num_req_p` (not modulo 2^width).
  - The winner is the first index in that order with `valid_i` set.
- **Ready.** `ready_o[k] = en & any(valid_i) & (k == winner)`. It is combinational from `valid_i`, `ptr`, lock state and `ready_i`. A requester never sees ready without a winner existing.
- **Transfer.** A transfer occurs when `valid_i[k] & ready_o[k]`. On transfer:
  - `data_l ← data_i[k]`, `last_l ← last_i[k]`, `src_l ← k`, `valid_l ← 1`.
  - `ptr ← (k+1) mod num_req_p`.
- **No transfer.**
  - If `en` is high: `valid_l ← 0`; `data_l`, `last_l` and `src_l` hold.
  - If `en` is low: the register and `ptr` hold.
- **Requester rules.** Requesters must hold `valid_i` and `data_i` stable until accepted. The arbiter does not depend on this for correctness; it only affects the requester's own protocol.
- **Reset (asynchronous, any time including mid-packet):**
  - `valid_o=0`, `data_o=0`, `last_o=0`, `src_o=0`, `ptr=0`, lock cleared.
  - `ready_o` is all zero while `reset_ni` is low.
  - An in-flight beat in the register is discarded.

## Timing
- Latency is 1 cycle: a beat accepted at edge n appears on `valid_o`/`data_o` after edge n.
- Throughput is 1 beat per cycle when `ready_i` is held high.
- Back-pressure: when `valid_o=1` and `ready_i=0`, every `ready_o` bit is 0 in the same cycle.
- Simultaneous drain and fill: when `ready_i=1` and `valid_o=1` in one cycle, the new winner is captured at the same edge the old beat leaves.
- Fairness: with all requesters continuously valid, the grant order is 0,1,…,N-1,0,…

## Configuration
- Macro: `RR_ELASTIC_ARBITER_LOCK_EN`.
- **Defined:** packet lock is enabled.
  - State: `lock_l` and `lock_id_l`.
  - A transfer from k with `last_i[k]=0` sets `lock_l ← 1` and `lock_id_l ← k`, and leaves `ptr` unchanged.
  - While locked, the winner is `lock_id_l` when `valid_i[lock_id_l]=1`; otherwise there is no winner (all `ready_o=0`). Other requesters wait.
  - A transfer with `last_i=1` from the lock holder clears the lock and sets `ptr ← lock_id_l+1 mod N`.
  - A single beat with `last_i=1` while unlocked behaves like the default mode.
- **Undefined:** every beat re-arbitrates.
  - `last_i` is only carried through to `last_o`.
  - `lock_l` and `lock_id_l` do not exist.

## Test plan
- **Reset:** hold `reset_ni=0`, all `valid_i=1` → `ready_o=0000`, `valid_o=0`, `data_o=0`, `src_o=0`. After release the first grant goes to requester 0.
- **Rotation:** N=4, all valid, `data_i[k]=0x10+k`, `ready_i=1` → `data_o` sequence 0x10,0x11,0x12,0x13,0x10, one beat per cycle, with `src_o` matching.
- **Back-pressure:** while `valid_o=1` with `data_o=0x11`, drop `ready_i` for 3 cycles → `ready_o=0000` and `data_o` stays 0x11. Raise `ready_i` → 0x12 is captured on the next edge.
- **Wrap:** N=3, only requesters 2 and 0 valid, `ptr=2` → grants 2,0,2,0. `ptr` never takes the value 3.
- **Lock (macro defined):** requester 1 sends 3 beats with `last`=0,0,1 while requester 2 is valid → `src_o`=1,1,1,2, with `ready_o[2]=0` during the packet. A 1-cycle gap in `valid_i[1]` mid-packet grants no one.
- **Asynchronous reset mid-packet:** assert `reset_ni` low between edges during a locked packet → outputs clear immediately and the lock is released. After release, requester 0 wins if valid.
